// File: rtl/per_out_capture.sv
// Peripheral-bus output capture: per-channel FIFOs with eof/ovf status,
// drained through a round-robin valid/ready stream port.
module per_out_capture #(
  parameter logic [13:0] BASE_ADDR = 14'h0080,
  parameter int          NUM_CH    = 2,
  parameter int          DEPTH     = 16
) (
  input  logic              mclk,
  input  logic              reset_n,
  input  logic              per_en,
  input  logic [13:0]       per_addr,
  input  logic [1:0]        per_we,
  input  logic [15:0]       per_din,
  output logic [15:0]       per_dout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        out_ch,
  output logic [15:0]       out_data,
  output logic [NUM_CH-1:0] eof_done
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [15:0]       r_mem [NUM_CH][DEPTH];
  logic [AW-1:0]     r_wp  [NUM_CH];
  logic [AW-1:0]     r_rp  [NUM_CH];
  logic [CW-1:0]     r_cnt [NUM_CH];
  logic [7:0]        r_ovf [NUM_CH];
  logic [NUM_CH-1:0] r_en;
  logic [NUM_CH-1:0] r_eof;
  logic [NUM_CH-1:0] r_eof_done;
  logic [2:0]        r_rr;
  logic              r_hold;
  logic [2:0]        r_hold_ch;

  logic [13:0]       w_off;
  logic              w_hit;
  logic [2:0]        w_ch;
  logic              w_reg;
  logic [15:0]       w_head [NUM_CH];
  logic [NUM_CH-1:0] w_ne;
  logic [NUM_CH-1:0] w_full;
  logic [NUM_CH-1:0] w_dwr;
  logic [NUM_CH-1:0] w_cwr;
  logic [NUM_CH-1:0] w_flush;
  logic [NUM_CH-1:0] w_pop;
  logic [NUM_CH-1:0] w_push;
  logic [NUM_CH-1:0] w_drop;
  logic              w_any;
  logic [2:0]        w_sel;

  assign w_off = per_addr - BASE_ADDR;
  assign w_hit = per_en && (w_off < 14'(2 * NUM_CH));
  assign w_ch  = w_off[3:1];
  assign w_reg = w_off[0];

  // A stalled word keeps its channel so the stream stays stable
  always_comb begin
    w_any = 1'b0;
    w_sel = '0;
    if (r_hold) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (r_hold_ch == 3'(c) && w_ne[c]) begin
          w_any = 1'b1;
          w_sel = 3'(c);
        end
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (!w_any && w_ne[c] &&
            c == (int'(r_rr) + i) % NUM_CH) begin
          w_any = 1'b1;
          w_sel = 3'(c);
        end
      end
    end
  end

  always_comb begin
    out_valid = w_any;
    out_ch    = w_any ? w_sel : 3'd0;
    out_data  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_any && w_sel == 3'(c))
        out_data = w_head[c];
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      w_head[c]  = r_mem[c][r_rp[c]];
      w_ne[c]    = r_cnt[c] != '0;
      w_full[c]  = r_cnt[c] == CW'(DEPTH);
      w_dwr[c]   = w_hit && !w_reg && w_ch == 3'(c) &&
                   per_we == 2'b11 && r_en[c];
      w_cwr[c]   = w_hit && w_reg && w_ch == 3'(c) &&
                   per_we[0];
      w_flush[c] = w_cwr[c] && per_din[0];
      w_pop[c]   = out_valid && out_ready &&
                   out_ch == 3'(c) && !w_flush[c];
      w_push[c]  = w_dwr[c] && per_din != '0 &&
                   (!w_full[c] || w_pop[c]) && !w_flush[c];
      w_drop[c]  = w_dwr[c] && per_din != '0 &&
                   w_full[c] && !w_pop[c];
    end
  end

  always_comb begin
    per_dout = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_hit && per_we == 2'b00 && w_ch == 3'(c)) begin
        if (w_reg)
          per_dout = {r_ovf[c], r_en[c], r_eof[c],
                      w_full[c], 5'(r_cnt[c])};
        else
          per_dout = w_ne[c] ? w_head[c] : '0;
      end
    end
  end

  always_ff @(posedge mclk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_push[c])
        r_mem[c][r_wp[c]] <= per_din;
    end
  end

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_wp[c]  <= '0;
        r_rp[c]  <= '0;
        r_cnt[c] <= '0;
        r_ovf[c] <= '0;
      end
      r_en       <= '1;
      r_eof      <= '0;
      r_eof_done <= '0;
      r_rr       <= '0;
      r_hold     <= 1'b0;
      r_hold_ch  <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_flush[c]) begin
          r_wp[c]  <= '0;
          r_rp[c]  <= '0;
          r_cnt[c] <= '0;
          r_ovf[c] <= '0;
          r_eof[c] <= 1'b0;
        end else begin
          if (w_push[c])
            r_wp[c] <= r_wp[c] + 1'b1;
          if (w_pop[c])
            r_rp[c] <= r_rp[c] + 1'b1;
          if (w_push[c] && !w_pop[c])
            r_cnt[c] <= r_cnt[c] + 1'b1;
          else if (!w_push[c] && w_pop[c])
            r_cnt[c] <= r_cnt[c] - 1'b1;
          if (w_dwr[c] && per_din == '0)
            r_eof[c] <= 1'b1;
          if (w_drop[c] && r_ovf[c] != 8'hFF)
            r_ovf[c] <= r_ovf[c] + 8'd1;
        end
        if (w_cwr[c])
          r_en[c] <= per_din[1];
        r_eof_done[c] <= r_eof[c] && !w_ne[c];
      end
      if (out_valid && out_ready)
        r_rr <= (out_ch == 3'(NUM_CH - 1)) ?
                3'd0 : out_ch + 3'd1;
      r_hold    <= out_valid && !out_ready;
      r_hold_ch <= out_ch;
    end
  end

  assign eof_done = r_eof_done;

endmodule

// File: tb/tb_per_out_capture.sv
// Bench for per_out_capture: register vector table plus
// scoreboarded stream sequences.
module tb_per_out_capture;
  localparam logic [13:0] D0 = 14'h0080;
  localparam logic [13:0] S0 = 14'h0081;
  localparam logic [13:0] D1 = 14'h0082;
  localparam logic [13:0] S1 = 14'h0083;

  logic        mclk = 1'b0;
  logic        reset_n;
  logic        per_en;
  logic [13:0] per_addr;
  logic [1:0]  per_we;
  logic [15:0] per_din;
  logic [15:0] per_dout;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_ch;
  logic [15:0] out_data;
  logic [1:0]  eof_done;

  int n_chk = 0;
  int n_err = 0;

  logic [15:0] q0[$];
  logic [15:0] q1[$];
  logic [2:0]  ch_log[$];

  per_out_capture dut (
    .mclk(mclk), .reset_n(reset_n), .per_en(per_en),
    .per_addr(per_addr), .per_we(per_we),
    .per_din(per_din), .per_dout(per_dout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ch(out_ch), .out_data(out_data),
    .eof_done(eof_done)
  );

  always #5 mclk = ~mclk;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic bus_wr(input logic [13:0] a,
                        input logic [1:0] we,
                        input logic [15:0] d);
    @(negedge mclk);
    per_en = 1'b1; per_addr = a; per_we = we; per_din = d;
    @(posedge mclk);
    #1;
    per_en = 1'b0; per_we = 2'b00;
  endtask

  task automatic bus_rd(input logic [13:0] a,
                        output logic [15:0] d);
    @(negedge mclk);
    per_en = 1'b1; per_addr = a; per_we = 2'b00;
    #1;
    d = per_dout;
    per_en = 1'b0;
  endtask

  task automatic rd_chk(input string nm,
                        input logic [13:0] a,
                        input logic [15:0] exp);
    logic [15:0] d;
    bus_rd(a, d);
    check(nm, 32'(d), 32'(exp));
  endtask

  task automatic wait_drain(input int max);
    int k = 0;
    while ((q0.size() + q1.size()) != 0 && k < max) begin
      @(negedge mclk);
      k++;
    end
    check("drain_timeout", q0.size() + q1.size(), 0);
  endtask

  // Scoreboard: a handshake seen here is consumed at the next rising edge
  always @(negedge mclk) begin
    #2;
    if (reset_n && out_valid && out_ready) begin
      logic [15:0] e;
      ch_log.push_back(out_ch);
      if (out_ch == 3'd0 && q0.size() != 0) begin
        e = q0.pop_front();
        check("stream_ch0", 32'(out_data), 32'(e));
      end else if (out_ch == 3'd1 && q1.size() != 0) begin
        e = q1.pop_front();
        check("stream_ch1", 32'(out_data), 32'(e));
      end else begin
        check("stream_unexpected", 32'(out_ch), 32'hFFFF);
      end
    end
  end

  typedef struct {
    bit          rd;
    logic [13:0] addr;
    logic [1:0]  we;
    logic [15:0] din;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[22];

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; out_ready = 1'b0;
    per_en = 1'b0; per_addr = '0; per_we = '0; per_din = '0;
    repeat (3) @(negedge mclk);
    #1;
    check("rst_valid", 32'(out_valid), 0);
    check("rst_ch", 32'(out_ch), 0);
    check("rst_data", 32'(out_data), 0);
    check("rst_eofd", 32'(eof_done), 0);
    check("rst_dout", 32'(per_dout), 0);
    @(negedge mclk);
    reset_n = 1'b1;
    rd_chk("rst_stat0", S0, 16'h0080);

    tbl[0]  = '{0, D0, 2'b11, 16'h1234, 16'h0000};
    tbl[1]  = '{1, S0, 2'b00, 16'h0000, 16'h0081};
    tbl[2]  = '{1, D0, 2'b00, 16'h0000, 16'h1234};
    tbl[3]  = '{0, D0, 2'b01, 16'h5555, 16'h0000};
    tbl[4]  = '{1, S0, 2'b00, 16'h0000, 16'h0081};
    tbl[5]  = '{0, D0, 2'b10, 16'h5555, 16'h0000};
    tbl[6]  = '{1, S0, 2'b00, 16'h0000, 16'h0081};
    tbl[7]  = '{0, S0, 2'b01, 16'h0000, 16'h0000};
    tbl[8]  = '{0, D0, 2'b11, 16'h7777, 16'h0000};
    tbl[9]  = '{1, S0, 2'b00, 16'h0000, 16'h0001};
    tbl[10] = '{0, D0, 2'b11, 16'h0000, 16'h0000};
    tbl[11] = '{1, S0, 2'b00, 16'h0000, 16'h0001};
    tbl[12] = '{0, S0, 2'b01, 16'h0002, 16'h0000};
    tbl[13] = '{1, S0, 2'b00, 16'h0000, 16'h0081};
    tbl[14] = '{1, 14'h0090, 2'b00, 16'h0000, 16'h0000};
    tbl[15] = '{1, D1, 2'b00, 16'h0000, 16'h0000};
    tbl[16] = '{1, S1, 2'b00, 16'h0000, 16'h0080};
    tbl[17] = '{0, S0, 2'b10, 16'h0001, 16'h0000};
    tbl[18] = '{1, S0, 2'b00, 16'h0000, 16'h0081};
    tbl[19] = '{0, S0, 2'b11, 16'h0003, 16'h0000};
    tbl[20] = '{1, S0, 2'b00, 16'h0000, 16'h0080};
    tbl[21] = '{1, D0, 2'b00, 16'h0000, 16'h0000};
    for (int i = 0; i < 22; i++) begin
      if (tbl[i].rd)
        rd_chk($sformatf("tbl%0d", i), tbl[i].addr, tbl[i].exp);
      else
        bus_wr(tbl[i].addr, tbl[i].we, tbl[i].din);
    end

    // eof after two words, streamed immediately
    out_ready = 1'b1;
    q0.push_back(16'h0011);
    bus_wr(D0, 2'b11, 16'h0011);
    q0.push_back(16'h0022);
    bus_wr(D0, 2'b11, 16'h0022);
    bus_wr(D0, 2'b11, 16'h0000);
    wait_drain(20);
    repeat (3) @(negedge mclk);
    #1;
    check("eof_done_set", 32'(eof_done), 32'h1);
    rd_chk("eof_stat0", S0, 16'h00C0);
    bus_wr(S0, 2'b01, 16'h0003);
    repeat (3) @(negedge mclk);
    #1;
    check("eof_done_clr", 32'(eof_done), 0);

    // overflow with a stalled consumer
    out_ready = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      if (q0.size() < 16) q0.push_back(16'(k));
      bus_wr(D0, 2'b11, 16'(k));
    end
    rd_chk("ovf_stat0", S0, 16'h01B0);
    #1;
    check("hold_valid", 32'(out_valid), 1);
    check("hold_data", 32'(out_data), 32'h0001);
    repeat (3) @(negedge mclk);
    #1;
    check("hold_ch", 32'(out_ch), 0);
    check("hold_data2", 32'(out_data), 32'h0001);

    // push and pop together while full
    @(negedge mclk);
    out_ready = 1'b1;
    per_en = 1'b1; per_addr = D0; per_we = 2'b11;
    per_din = 16'h0018;
    q0.push_back(16'h0018);
    @(posedge mclk);
    #1;
    out_ready = 1'b0; per_en = 1'b0; per_we = 2'b00;
    rd_chk("pp_stat0", S0, 16'h01B0);
    rd_chk("pp_head", D0, 16'h0002);
    bus_wr(D0, 2'b11, 16'h0019);
    rd_chk("ovf2_stat0", S0, 16'h02B0);
    for (int k = 0; k < 260; k++)
      bus_wr(D0, 2'b11, 16'h0abc);
    rd_chk("ovf_sat", S0, 16'hFFB0);
    bus_wr(S0, 2'b11, 16'h0003);
    q0.delete();
    check("flush_valid", 32'(out_valid), 0);
    rd_chk("flush_stat0", S0, 16'h0080);

    // interleaved channels drain round-robin
    for (int k = 0; k < 3; k++) begin
      q0.push_back(16'h00A0 + 16'(k));
      bus_wr(D0, 2'b11, 16'h00A0 + 16'(k));
      q1.push_back(16'h00B0 + 16'(k));
      bus_wr(D1, 2'b11, 16'h00B0 + 16'(k));
    end
    ch_log.delete();
    @(negedge mclk);
    out_ready = 1'b1;
    wait_drain(40);
    @(negedge mclk);
    out_ready = 1'b0;
    check("rr_len", ch_log.size(), 6);
    for (int i = 0; i < 6 && i < ch_log.size(); i++)
      check($sformatf("rr_ch%0d", i), 32'(ch_log[i]), i % 2);

    // asynchronous reset with words queued
    for (int k = 1; k <= 5; k++) begin
      q1.push_back(16'h0100 + 16'(k));
      bus_wr(D1, 2'b11, 16'h0100 + 16'(k));
    end
    bus_wr(D0, 2'b11, 16'h0000);
    repeat (3) @(negedge mclk);
    #1;
    check("pre_eofd", 32'(eof_done), 32'h1);
    check("pre_valid", 32'(out_valid), 1);
    check("pre_ch", 32'(out_ch), 1);
    @(negedge mclk);
    per_en = 1'b1; per_addr = D1; per_we = 2'b00;
    #1;
    check("pre_dout", 32'(per_dout), 32'h0101);
    #1;
    reset_n = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 0);
    check("arst_eofd", 32'(eof_done), 0);
    check("arst_dout", 32'(per_dout), 0);
    check("arst_data", 32'(out_data), 0);
    per_en = 1'b0;
    q0.delete();
    q1.delete();
    repeat (2) @(negedge mclk);
    reset_n = 1'b1;
    rd_chk("post_stat1", S1, 16'h0080);
    rd_chk("post_stat0", S0, 16'h0080);

    repeat (2) @(negedge mclk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
